mux4_sel: RTL and testbench

- Four-input, WIDTH-bit multiplexer selected by a 2-bit code.
- Provides a combinational output `ot` for zero-latency datapath use.
- Provides a registered copy `ot_q`, with a valid flag, for timing-closed consumers.
- Leaf block, used wherever one of four equal-width operands must be steered onto a single bus.

---
 rtl/mux4_sel_pkg.sv | 14 +
 rtl/mux4_sel_core.sv | 27 ++
 rtl/mux4_sel.sv | 56 +++++
 tb/tb_mux4_sel.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mux4_sel_pkg.sv
// Shared types and defaults for the mux4_sel selector family.
// Optional build macro used by dependents: MUX4_SEL_PARITY_EN.
package mux4_sel_pkg;

  typedef enum logic [1:0] {
    SEL_I1 = 2'd0,
    SEL_I2 = 2'd1,
    SEL_I3 = 2'd2,
    SEL_I4 = 2'd3
  } sel_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/mux4_sel_core.sv
// Combinational WIDTH-bit 4:1 selector; unknown select codes steer i1 through.
module mux4_sel_core
  import mux4_sel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  sel_t             s,
  output logic [WIDTH-1:0] ot
);

  // Default arm catches X/Z on s so the output never goes unknown from the select.
  always_comb begin
    ot = i1;
    case (s)
      SEL_I1:  ot = i1;
      SEL_I2:  ot = i2;
      SEL_I3:  ot = i3;
      SEL_I4:  ot = i4;
      default: ot = i1;
    endcase
  end

endmodule

// File: rtl/mux4_sel.sv
// 4:1 mux with zero-latency output plus an enabled capture register and valid flag.
// Build macro MUX4_SEL_PARITY_EN adds par_q, the XOR of the captured word.
module mux4_sel
  import mux4_sel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  sel_t             s,
  input  logic             en,
  output logic [WIDTH-1:0] ot,
`ifdef MUX4_SEL_PARITY_EN
  output logic             par_q,
`endif
  output logic [WIDTH-1:0] ot_q,
  output logic             vld_q
);

  mux4_sel_core #(.WIDTH(WIDTH)) u_core (
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .i4 (i4),
    .s  (s),
    .ot (ot)
  );

  // vld_q marks a capture on the most recent edge, so it drops whenever en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ot_q  <= '0;
      vld_q <= 1'b0;
    end else if (en) begin
      ot_q  <= ot;
      vld_q <= 1'b1;
    end else begin
      vld_q <= 1'b0;
    end
  end

`ifdef MUX4_SEL_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (en) begin
      par_q <= ^ot;
    end
  end
`endif

endmodule

// File: tb/tb_mux4_sel.sv
// Directed bench for mux4_sel: combinational output checks plus a scoreboard for the register stage.
module tb_mux4_sel;
  import mux4_sel_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] i1, i2, i3, i4;
  sel_t         s;
  logic         en;
  logic [W-1:0] ot, ot_q;
  logic         vld_q;
`ifdef MUX4_SEL_PARITY_EN
  logic         par_q;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard entry: {parity, valid, captured word}
  logic [W+1:0] sb_q[$];
  logic [W-1:0] last_q = '0;
  logic         last_v = 1'b0;
  logic         last_p = 1'b0;

  mux4_sel #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .i4    (i4),
    .s     (s),
    .en    (en),
    .ot    (ot),
`ifdef MUX4_SEL_PARITY_EN
    .par_q (par_q),
`endif
    .ot_q  (ot_q),
    .vld_q (vld_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_mux(input logic [W-1:0] a, b, c, d, input logic [1:0] sv);
    logic [W-1:0] arr [4];
    arr[0] = a; arr[1] = b; arr[2] = c; arr[3] = d;
    return arr[sv];
  endfunction

  task automatic check_regs(input string tag);
    logic [W+1:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_ot_q"}, 32'(ot_q), 32'(e[W-1:0]));
    chk({tag, "_vld_q"}, 32'(vld_q), 32'(e[W]));
`ifdef MUX4_SEL_PARITY_EN
    chk({tag, "_par_q"}, 32'(par_q), 32'(e[W+1]));
`endif
  endtask

  // Drive at negedge, check ot, push the expected register state, check it after the next posedge.
  task automatic step(input string tag, input logic [W-1:0] a, b, c, d,
                      input sel_t sv, input logic e, input logic [W-1:0] exp_ot);
    @(negedge clk);
    i1 = a; i2 = b; i3 = c; i4 = d; s = sv; en = e;
    #1;
    chk({tag, "_ot"}, 32'(ot), 32'(exp_ot));
    if (e) begin
      last_q = exp_ot;
      last_v = 1'b1;
      last_p = ^exp_ot;
    end else begin
      last_v = 1'b0;
    end
    sb_q.push_back({last_p, last_v, last_q});
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]   xs;
    logic [W-1:0] ra, rb, rc, rd;
    logic [1:0]   rs;
    logic         re;

    i1 = '0; i2 = '0; i3 = '0; i4 = '0; s = SEL_I1; en = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_ot_q", 32'(ot_q), 32'd0);
    chk("reset_vld_q", 32'(vld_q), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    step("all_zero", 4'b0000, 4'b0000, 4'b0000, 4'b0000, SEL_I1, 1'b1, 4'b0000);
    step("s01",      4'b1111, 4'b1000, 4'b0111, 4'b1001, SEL_I2, 1'b1, 4'b1000);
    step("sweep_s00", 4'b1101, 4'b0100, 4'b0100, 4'b1101, SEL_I1, 1'b1, 4'b1101);
    step("sweep_s11", 4'b0111, 4'b0110, 4'b1000, 4'b1100, SEL_I4, 1'b1, 4'b1100);
    step("sweep_s01", 4'b0001, 4'b0100, 4'b0010, 4'b1110, SEL_I2, 1'b1, 4'b0100);
    step("sweep_s10", 4'b0001, 4'b0100, 4'b0010, 4'b1110, SEL_I3, 1'b1, 4'b0010);
    step("all_ones", 4'b1111, 4'b1111, 4'b1111, 4'b1111, SEL_I4, 1'b1, 4'b1111);

    step("cap_1000", 4'b1111, 4'b1000, 4'b0111, 4'b1001, SEL_I2, 1'b1, 4'b1000);
    step("hold_a",   4'b1111, 4'b0011, 4'b0111, 4'b1001, SEL_I2, 1'b0, 4'b0011);
    step("hold_b",   4'b1111, 4'b0011, 4'b0111, 4'b0110, SEL_I4, 1'b0, 4'b0110);

    for (int unsigned k = 0; k < 12; k++) begin
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
      rs = 2'($urandom); re = 1'($urandom);
      step("rand", ra, rb, rc, rd, sel_t'(rs), re, model_mux(ra, rb, rc, rd, rs));
    end

    step("pre_rst", 4'b0101, 4'b1010, 4'b0110, 4'b1001, SEL_I3, 1'b1, 4'b0110);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ot_q", 32'(ot_q), 32'd0);
    chk("midrst_vld_q", 32'(vld_q), 32'd0);
`ifdef MUX4_SEL_PARITY_EN
    chk("midrst_par_q", 32'(par_q), 32'd0);
`endif
    i3 = 4'b1100;
    #1;
    chk("midrst_ot_follows", 32'(ot), 32'(4'b1100));
    @(posedge clk);
    #1;
    chk("rst_held_ot_q", 32'(ot_q), 32'd0);
    chk("rst_held_vld_q", 32'(vld_q), 32'd0);
    last_q = '0; last_v = 1'b0; last_p = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step("post_rst", 4'b0101, 4'b1010, 4'b0110, 4'b1001, SEL_I2, 1'b1, 4'b1010);

    xs = 2'bx1;
    step("x_sel", 4'b1010, 4'b1010, 4'b0101, 4'b1010, sel_t'(xs), 1'b1, 4'b1010);
    chk("x_noprop", 32'($isunknown(ot_q)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
